// File: rtl/bcd_pkg.sv
// Shared sizing and state encoding for the sequential BCD-to-binary converter.
package bcd_pkg;
    localparam int NDIG = 12;
    localparam int DIGW = 5;
    localparam int BW   = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble nibble correction: take 3 off any digit that reached 8 or more.
module bcd_sub3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd8) ? i_nib - 4'd3 : i_nib;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one bit per cycle, reverse double-dabble.
// The first SHIFT cycle only resolves the digit check, so the BW shifts start one cycle later.
module bcd_to_bin_seq #(
    parameter int NDIG = bcd_pkg::NDIG,
    parameter int BW   = bcd_pkg::BW
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [bcd_pkg::DIGW*NDIG-1:0] DIGITS,
    output logic                          BUSY,
    output logic                          VALID,
    output logic                          ERR,
    output logic [BW-1:0]                 BIN
);
    import bcd_pkg::*;

    localparam int CW = $clog2(BW + 1);

    state_t              r_state;
    state_t              w_next;
    logic [4*NDIG-1:0]   r_bcd;
    logic [BW-1:0]       r_work;
    logic [CW-1:0]       r_cnt;
    logic                r_bad;
    logic [BW-1:0]       r_bin;
    logic                r_err;

    logic [4*NDIG-1:0]   w_nib_in;
    logic [NDIG-1:0]     w_fld_bad;
    logic [4*NDIG-1:0]   w_bcd_shr;
    logic [4*NDIG-1:0]   w_bcd_nxt;
    logic [BW-1:0]       w_work_nxt;
    logic                w_last;

    assign w_bcd_shr  = {1'b0, r_bcd[4*NDIG-1:1]};
    assign w_work_nxt = {r_bcd[0], r_work[BW-1:1]};
    assign w_last     = (r_cnt == CW'(BW));

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign w_nib_in[4*g +: 4] = DIGITS[DIGW*g +: 4];
        assign w_fld_bad[g]       = (DIGITS[DIGW*g +: DIGW] > DIGW'(9));

        bcd_sub3 u_sub3 (
            .i_nib (w_bcd_shr[4*g +: 4]),
            .o_nib (w_bcd_nxt[4*g +: 4])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (START) w_next = SHIFT;
            SHIFT:   if ((r_cnt == '0 && r_bad) || w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_bcd  <= '0;
            r_work <= '0;
            r_cnt  <= '0;
            r_bad  <= 1'b0;
            r_bin  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (START) begin
                    r_bcd  <= w_nib_in;
                    r_bad  <= |w_fld_bad;
                    r_work <= '0;
                    r_cnt  <= '0;
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        // Check cycle: an illegal request skips every shift.
                        if (r_bad) begin
                            r_bin <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= CW'(1);
                        end
                    end else begin
                        r_bcd  <= w_bcd_nxt;
                        r_work <= w_work_nxt;
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_bin <= w_work_nxt;
                            r_err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY  = (r_state != IDLE);
    assign VALID = (r_state == DONE);
    assign ERR   = r_err;
    assign BIN   = r_bin;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Table-driven bench with an expected-result queue popped on every VALID pulse.
module tb_bcd_to_bin_seq;
    localparam int NDIG = 12;
    localparam int BW   = 40;
    localparam int LAT  = BW + 1;

    typedef struct {
        logic [59:0] digits;
        logic [39:0] bin;
        logic        err;
    } vec_t;

    typedef struct {
        logic [39:0] bin;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [59:0] DIGITS = '0;
    logic        BUSY, VALID, ERR;
    logic [39:0] BIN;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_valid = 0;
    exp_t q[$];
    vec_t tbl[11];

    bcd_to_bin_seq #(.NDIG(NDIG), .BW(BW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .DIGITS (DIGITS),
        .BUSY   (BUSY),
        .VALID  (VALID),
        .ERR    (ERR),
        .BIN    (BIN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [59:0] fld(input logic [47:0] b);
        logic [59:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) r[i*5 +: 5] = {1'b0, b[i*4 +: 4]};
        return r;
    endfunction

    function automatic logic [59:0] setf(input logic [59:0] v, input int idx, input logic [4:0] val);
        logic [59:0] r;
        r = v;
        r[idx*5 +: 5] = val;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every VALID pulse must match the oldest outstanding request.
    always @(negedge CLK) begin
        exp_t e;
        if (VALID) begin
            n_valid++;
            n_chk++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got BIN=0x%0h ERR=%0b with nothing outstanding", BIN, ERR);
            end else begin
                e = q.pop_front();
                if (BIN !== e.bin || ERR !== e.err) begin
                    n_err++;
                    $display("FAIL result: got BIN=0x%0h ERR=%0b expected BIN=0x%0h ERR=%0b", BIN, ERR, e.bin, e.err);
                end
                if (!e.err) begin
                    n_chk++;
                    assert (dut.r_bcd == '0)
                    else begin
                        n_err++;
                        $display("FAIL bcd_residue: got 0x%0h expected 0", dut.r_bcd);
                    end
                end
            end
        end
    end

    task automatic accept(input logic [59:0] d, input logic [39:0] b, input logic e, input bit push);
        exp_t x;
        @(negedge CLK);
        START  = 1'b1;
        DIGITS = d;
        if (push) begin
            x.bin = b;
            x.err = e;
            q.push_back(x);
        end
        @(posedge CLK);
        #1;
        START  = 1'b0;
        DIGITS = 60'({$urandom(), $urandom()});
        chk("busy_after_accept", 40'(BUSY), 40'd1);
    endtask

    task automatic wait_valid(input int exp_lat, input string nm);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
            got = VALID;
        end
        n_chk++;
        if (!got || lat != exp_lat) begin
            n_err++;
            $display("FAIL latency_%s: got %0d cycles (valid seen=%0b) expected %0d", nm, lat, got, exp_lat);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int v0;

        tbl[0]  = '{fld(48'h000000000000), 40'h0,          1'b0};
        tbl[1]  = '{fld(48'h999999999999), 40'hE8D4A50FFF, 1'b0};
        tbl[2]  = '{fld(48'h000000001234), 40'h4D2,        1'b0};
        tbl[3]  = '{fld(48'h000000000007), 40'h7,          1'b0};
        tbl[4]  = '{setf(fld(48'h000000001234), 1, 5'd10), 40'h0, 1'b1};
        tbl[5]  = '{setf(fld(48'h000000001234), 1, 5'd16), 40'h0, 1'b1};
        tbl[6]  = '{fld(48'h000000000042), 40'h2A,         1'b0};
        tbl[7]  = '{fld(48'h123456789012), 40'h1CBE991A14, 1'b0};
        tbl[8]  = '{setf(fld(48'h000000000000), 0, 5'd15), 40'h0, 1'b1};
        tbl[9]  = '{setf(fld(48'h999999999999), 11, 5'd31), 40'h0, 1'b1};
        tbl[10] = '{fld(48'h000000100000), 40'h186A0,      1'b0};

        // Reset with START held high: reset must win.
        RST   = 1'b0;
        START = 1'b1;
        DIGITS = fld(48'h000000000055);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",  40'(BUSY),  40'd0);
        chk("rst_valid", 40'(VALID), 40'd0);
        chk("rst_err",   40'(ERR),   40'd0);
        chk("rst_bin",   BIN,        40'd0);
        START = 1'b0;
        RST   = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_after_rst_start", 40'(BUSY), 40'd0);

        for (int i = 0; i < 11; i++) begin
            accept(tbl[i].digits, tbl[i].bin, tbl[i].err, 1'b1);
            wait_valid(tbl[i].err ? 1 : LAT, $sformatf("vec%0d", i));
            chk($sformatf("hold_bin_vec%0d", i), BIN, tbl[i].bin);
        end

        // Second START mid-conversion is dropped.
        v0 = n_valid;
        accept(fld(48'h000000001234), 40'h4D2, 1'b0, 1'b1);
        repeat (5) @(posedge CLK);
        #1;
        START  = 1'b1;
        DIGITS = fld(48'h000000000001);
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_valid(LAT - 6, "busy_start");
        repeat (60) @(posedge CLK);
        #1;
        chk("single_valid", 40'(n_valid - v0), 40'd1);
        chk("busy_idle",    40'(BUSY),         40'd0);
        chk("bin_held",     BIN,               40'h4D2);

        // Reset at shift 20 aborts silently, START during reset ignored.
        v0 = n_valid;
        accept(fld(48'h000000001234), 40'h0, 1'b0, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        RST   = 1'b0;
        START = 1'b1;
        @(posedge CLK);
        #1;
        RST   = 1'b1;
        START = 1'b0;
        chk("abort_busy",  40'(BUSY),  40'd0);
        chk("abort_valid", 40'(VALID), 40'd0);
        chk("abort_err",   40'(ERR),   40'd0);
        chk("abort_bin",   BIN,        40'd0);
        repeat (60) @(posedge CLK);
        #1;
        chk("abort_no_valid", 40'(n_valid - v0), 40'd0);
        accept(fld(48'h000000000042), 40'h2A, 1'b0, 1'b1);
        wait_valid(LAT, "after_abort");

        chk("queue_drained", 40'(q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end
endmodule
